// File: rtl/multi_complex_freq_pkg.sv
// rtl/multi_complex_freq_pkg.sv - shared constants for the multi-channel frequency/amplitude monitor
package multi_complex_freq_pkg;

    localparam logic [1:0] Q_PP = 2'd0;
    localparam logic [1:0] Q_NP = 2'd1;
    localparam logic [1:0] Q_NN = 2'd2;
    localparam logic [1:0] Q_PN = 2'd3;

    // (q_new - q_old) mod 4
    localparam logic [1:0] D_HOLD = 2'd0;
    localparam logic [1:0] D_INC  = 2'd1;
    localparam logic [1:0] D_SKIP = 2'd2;
    localparam logic [1:0] D_DEC  = 2'd3;

    localparam int UPD_LAT = 3;

    function automatic logic [1:0] quadrant(input logic i_neg, input logic q_neg);
        case ({i_neg, q_neg})
            2'b00:   quadrant = Q_PP;
            2'b10:   quadrant = Q_NP;
            2'b11:   quadrant = Q_NN;
            default: quadrant = Q_PN;
        endcase
    endfunction

endpackage

// File: rtl/multi_complex_freq_quad_tracker.sv
// rtl/multi_complex_freq_quad_tracker.sv - per-pair quadrant transition and count update
module multi_complex_freq_quad_tracker
    import multi_complex_freq_pkg::*;
#(
    parameter int FW = 17
) (
    input  logic                 i_neg,
    input  logic                 q_neg,
    input  logic [1:0]           q_old,
    input  logic                 seeded,
    input  logic signed [FW-1:0] count_in,
    input  logic                 invalid_in,
    output logic [1:0]           q_new,
    output logic signed [FW-1:0] count_out,
    output logic                 invalid_out,
    output logic                 sat
);

    localparam logic signed [FW-1:0] CNT_MAX = {1'b0, {(FW-1){1'b1}}};
    localparam logic signed [FW-1:0] CNT_MIN = {1'b1, {(FW-1){1'b0}}};

    logic [1:0] d;

    assign q_new = quadrant(i_neg, q_neg);
    assign d     = q_new - q_old;

    always_comb begin
        count_out   = count_in;
        invalid_out = invalid_in;
        sat         = 1'b0;
        // An unseeded channel only records its starting quadrant.
        if (seeded) begin
            case (d)
                D_INC: begin
                    if (count_in == CNT_MAX) sat = 1'b1;
                    else                     count_out = count_in + FW'(1);
                end
                D_DEC: begin
                    if (count_in == CNT_MIN) sat = 1'b1;
                    else                     count_out = count_in - FW'(1);
                end
                D_SKIP:  invalid_out = 1'b1;
                D_HOLD:  count_out = count_in;
                default: count_out = count_in;
            endcase
        end
    end

endmodule

// File: rtl/multi_complex_freq.sv
// rtl/multi_complex_freq.sv - multi-channel I/Q quadrant frequency counter with min/max magnitude tracking
module multi_complex_freq
    import multi_complex_freq_pkg::*;
#(
    parameter int DW  = 18,
    parameter int NCH = 4,
    parameter int CHW = 2,
    parameter int FW  = 17,
    parameter int AW  = 17,
    parameter int PW  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic signed [DW-1:0] s_data,
    input  logic                 s_valid,
    input  logic                 s_iq,
    input  logic [CHW-1:0]       s_chan,
    input  logic [PW-1:0]        period,
    input  logic [CHW-1:0]       rd_chan,
    output logic signed [FW-1:0] rd_freq,
    output logic                 rd_freq_valid,
    output logic [AW-1:0]        rd_amp_max,
    output logic [AW-1:0]        rd_amp_min,
    output logic                 updated,
    output logic [CHW-1:0]       upd_chan,
    output logic                 protocol_err
);

    localparam int PL = UPD_LAT - 1;

    // Beat protocol state
    logic           pend;
    logic [CHW-1:0] pend_chan;
    logic           pend_ineg;
    logic           in_range, rd_in_range, last_chan;
    logic           pair_ok, err, mark;
    logic [CHW-1:0] mark_chan;

    // Frame / window control
    logic [PW-1:0]  frame_cnt, act_period, period_eff;
    logic [PW:0]    frame_next;
    logic           frame_done;
    logic [NCH-1:0] close_pend;

    // Pipeline entries travelling alongside the multiplier
    logic           pipe_pair [PL];
    logic           pipe_fin  [PL];
    logic           pipe_mark [PL];
    logic           pipe_ineg [PL];
    logic           pipe_qneg [PL];
    logic [CHW-1:0] pipe_chan [PL];

    logic signed [DW-1:0]   x_r;
    logic                   x_i;
    logic signed [2*DW-1:0] x_ext, sq;
    logic [2*DW-1:0]        isq, mag2;

    // Per-channel state and readout storage
    logic [1:0]           q_old    [NCH];
    logic signed [FW-1:0] cnt      [NCH];
    logic [AW-1:0]        amin     [NCH];
    logic [AW-1:0]        amax     [NCH];
    logic [NCH-1:0]       inv, seeded, started;
    logic signed [FW-1:0] res_freq [NCH];
    logic [AW-1:0]        res_min  [NCH];
    logic [AW-1:0]        res_max  [NCH];
    logic [NCH-1:0]       res_valid;

    logic [CHW-1:0]       c;
    logic [1:0]           trk_q;
    logic signed [FW-1:0] trk_cnt;
    logic                 trk_inv, trk_sat;
    logic [AW-1:0]        amp, min_next, max_next;

    assign in_range    = 32'(s_chan) < NCH;
    assign rd_in_range = 32'(rd_chan) < NCH;
    assign last_chan   = s_chan == CHW'(NCH - 1);
    assign period_eff  = (period == '0) ? PW'(1) : period;
    assign frame_next  = {1'b0, frame_cnt} + {{PW{1'b0}}, 1'b1};
    assign frame_done  = pair_ok && last_chan && (frame_next >= {1'b0, act_period});

    always_comb begin
        pair_ok   = 1'b0;
        err       = 1'b0;
        mark      = 1'b0;
        mark_chan = pend_chan;
        if (s_valid) begin
            if (!s_iq) begin
                if (pend || !in_range) begin
                    err  = 1'b1;
                    mark = pend;
                end
            end else if (pend && s_chan == pend_chan) begin
                pair_ok = 1'b1;
            end else begin
                err = 1'b1;
                if (pend) begin
                    mark = 1'b1;
                end else if (in_range) begin
                    mark      = 1'b1;
                    mark_chan = s_chan;
                end
            end
        end
    end

    // Shared squarer: the I square waits in isq until its Q beat arrives.
    assign x_ext = {{DW{x_r[DW-1]}}, x_r};
    assign sq    = x_ext * x_ext;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend         <= 1'b0;
            pend_chan    <= '0;
            pend_ineg    <= 1'b0;
            protocol_err <= 1'b0;
            frame_cnt    <= '0;
            act_period   <= PW'(1);
            close_pend   <= '0;
            x_r          <= '0;
            x_i          <= 1'b0;
            isq          <= '0;
            mag2         <= '0;
            for (int k = 0; k < PL; k++) begin
                pipe_pair[k] <= 1'b0;
                pipe_fin[k]  <= 1'b0;
                pipe_mark[k] <= 1'b0;
                pipe_ineg[k] <= 1'b0;
                pipe_qneg[k] <= 1'b0;
                pipe_chan[k] <= '0;
            end
        end else begin
            protocol_err <= err;
            if (s_valid) begin
                if (!s_iq) begin
                    pend      <= in_range;
                    pend_chan <= s_chan;
                    pend_ineg <= s_data[DW-1];
                end else begin
                    pend <= 1'b0;
                end
                x_r <= s_data;
            end
            x_i <= s_valid && !s_iq;

            if (pair_ok && last_chan) begin
                if (frame_done) begin
                    frame_cnt  <= '0;
                    act_period <= period_eff;
                end else begin
                    frame_cnt  <= frame_next[PW-1:0];
                end
            end
            // A close arms every channel; its next valid pair becomes the final one.
            if (pair_ok)    close_pend[s_chan] <= 1'b0;
            if (frame_done) close_pend <= '1;

            pipe_pair[0] <= pair_ok;
            pipe_fin[0]  <= pair_ok && close_pend[s_chan];
            pipe_mark[0] <= mark;
            pipe_ineg[0] <= pend_ineg;
            pipe_qneg[0] <= s_data[DW-1];
            pipe_chan[0] <= mark ? mark_chan : s_chan;
            for (int k = 1; k < PL; k++) begin
                pipe_pair[k] <= pipe_pair[k-1];
                pipe_fin[k]  <= pipe_fin[k-1];
                pipe_mark[k] <= pipe_mark[k-1];
                pipe_ineg[k] <= pipe_ineg[k-1];
                pipe_qneg[k] <= pipe_qneg[k-1];
                pipe_chan[k] <= pipe_chan[k-1];
            end

            if (x_i)          isq  <= sq;
            if (pipe_pair[0]) mag2 <= isq + sq;
        end
    end

    assign c   = pipe_chan[PL-1];
    assign amp = mag2[2*DW-1 -: AW];

    multi_complex_freq_quad_tracker #(.FW(FW)) u_quad_tracker (
        .i_neg       (pipe_ineg[PL-1]),
        .q_neg       (pipe_qneg[PL-1]),
        .q_old       (q_old[c]),
        .seeded      (seeded[c]),
        .count_in    (cnt[c]),
        .invalid_in  (inv[c]),
        .q_new       (trk_q),
        .count_out   (trk_cnt),
        .invalid_out (trk_inv),
        .sat         (trk_sat)
    );

    always_comb begin
        min_next = amp;
        max_next = amp;
        if (started[c]) begin
            min_next = (amp < amin[c]) ? amp : amin[c];
            max_next = (amp > amax[c]) ? amp : amax[c];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inv           <= '0;
            seeded        <= '0;
            started       <= '0;
            res_valid     <= '0;
            updated       <= 1'b0;
            upd_chan      <= '0;
            rd_freq       <= '0;
            rd_freq_valid <= 1'b0;
            rd_amp_max    <= '0;
            rd_amp_min    <= '0;
            for (int k = 0; k < NCH; k++) begin
                q_old[k]    <= '0;
                cnt[k]      <= '0;
                amin[k]     <= '0;
                amax[k]     <= '0;
                res_freq[k] <= '0;
                res_min[k]  <= '0;
                res_max[k]  <= '0;
            end
        end else begin
            updated <= 1'b0;
            if (pipe_pair[PL-1]) begin
                q_old[c]  <= trk_q;
                seeded[c] <= 1'b1;
                if (pipe_fin[PL-1]) begin
                    res_freq[c]  <= trk_cnt;
                    res_valid[c] <= ~(trk_inv | trk_sat);
                    res_min[c]   <= min_next;
                    res_max[c]   <= max_next;
                    cnt[c]       <= '0;
                    inv[c]       <= 1'b0;
                    started[c]   <= 1'b0;
                    amin[c]      <= '0;
                    amax[c]      <= '0;
                    updated      <= 1'b1;
                    upd_chan     <= c;
                end else begin
                    cnt[c]     <= trk_cnt;
                    inv[c]     <= trk_inv | trk_sat;
                    started[c] <= 1'b1;
                    amin[c]    <= min_next;
                    amax[c]    <= max_next;
                end
            end else if (pipe_mark[PL-1]) begin
                inv[c] <= 1'b1;
            end

            rd_freq       <= rd_in_range ? res_freq[rd_chan]  : '0;
            rd_freq_valid <= rd_in_range ? res_valid[rd_chan] : 1'b0;
            rd_amp_max    <= rd_in_range ? res_max[rd_chan]   : '0;
            rd_amp_min    <= rd_in_range ? res_min[rd_chan]   : '0;
        end
    end

endmodule

// File: doc/multi_complex_freq.md
Name: multi_complex_freq

Overview:
- Multi-channel, parametrised successor to the single-channel complex frequency/amplitude monitor.
- Accepts a time-multiplexed I/Q stream for NCH channels and counts quadrant transitions per channel to give signed frequency over a programmable window.
- Tracks per-channel min/max magnitude-squared and reports protocol errors.
- Sits after the digital down-converter mux; results are read through a channel-addressed readout port by the local-bus register layer.

Parameters:
- DW, 18, signed sample width.
- NCH, 4, number of channels (power of two not required).
- CHW, 2, channel index width; must satisfy 2^CHW >= NCH.
- FW, 17, signed quadrant-count width.
- AW, 17, reported magnitude width; top AW bits of the 2*DW-bit magnitude-squared.
- PW, 16, window-period width, in frames.

Ports:
- clk  in  1  single clock domain
- rst_n  in  1  synchronous, active-low reset
- s_data  in  DW  signed sample
- s_valid  in  1  sample strobe
- s_iq  in  1  0 = I beat, 1 = Q beat
- s_chan  in  CHW  channel of this beat
- period  in  PW  window length in frames; sampled at each rollover
- rd_chan  in  CHW  readout channel select
- rd_freq  out  FW  signed quadrant count of last closed window
- rd_freq_valid  out  1  window closed with no invalid transition or protocol error
- rd_amp_max  out  AW  maximum magnitude-squared (truncated) in last window
- rd_amp_min  out  AW  minimum magnitude-squared (truncated) in last window
- updated  out  1  one-cycle pulse when a channel's results are latched
- upd_chan  out  CHW  channel latched on the updated pulse
- protocol_err  out  1  one-cycle pulse on an illegal beat sequence

Behaviour:
- Reset (rst_n low at a clk edge):
  - all outputs 0;
  - all per-channel accumulators, latched results and seeded flags 0;
  - frame counter 0, active period 1.
  - Reset asserted mid-window discards all partial results.
- Beat protocol:
  - An I beat for channel c must be followed, on the next s_valid, by a Q beat for the same c. Idle cycles between the two beats are allowed.
  - A Q beat with no pending I, a Q beat for a different channel, an I beat while an I is pending, or s_chan >= NCH each cause:
    - a protocol_err pulse 1 cycle later;
    - the offending pair is dropped;
    - channel c's window, or the offending channel's window, is marked invalid.
- Quadrant: q=0 for I>=0,Q>=0; q=1 for I<0,Q>=0; q=2 for I<0,Q<0; q=3 for I>=0,Q<0.
- Transition handling: d = (q - q_old[c]) mod 4.
  - d=0: no change.
  - d=1: count +1.
  - d=3: count -1.
  - d=2: window invalid.
  - Count saturates at the FW-bit signed limits; saturation also marks the window invalid.
  - The first pair after reset only seeds q_old[c]; no count.
  - q_old persists across rollover, so there is no reseed.
- Magnitude: mag2 = I*I + Q*Q, held as unsigned 2*DW bits.
  - One shared multiplier, pipelined: the I square is registered, the Q square is added on the next product.
  - amp value = mag2[2*DW-1 -: AW].
  - The first pair of a window loads both min and max; later pairs update by strict compare.
- Frames and windows:
  - The frame counter increments on each valid Q beat of channel NCH-1.
  - When the count reaches the active period, the frame closes. Each channel's next valid pair after the close is that channel's final pair.
  - The final pair is included in the window's results, then the following are latched into readout storage: count, valid = ~invalid, min, max.
  - The accumulators are then cleared.
  - period=0 is treated as 1. A new period value takes effect only at the rollover.
- Latency:
  - updated pulses, with upd_chan, 3 cycles after the final Q beat of that channel.
  - rd_* outputs are registered, 1 cycle after rd_chan changes.
  - A read of the channel being latched in the same cycle returns the old value, and returns the new value on the next cycle.
- No backpressure. Back-to-back pairs, one beat per cycle, are fully supported.

Decomposition:
- Shared package holds:
  - quadrant encoding constants Q_PP=0, Q_NP=1, Q_NN=2, Q_PN=3;
  - transition decode constants;
  - the pipeline latency constant UPD_LAT=3.
- One natural sub-module, quad_tracker. It is pure per-pair logic: it takes the signs of I and Q, q_old, count and the invalid flag, and returns next-state values plus saturation.
- The top level holds the per-channel state arrays, the multiplier pipeline, and the frame/window control.

Test Plan:
- Reset, then NCH=4, period=2, channel 1 rotating CCW one quadrant per frame, starting at (+1000,+1000) → channel 1 latches rd_freq=+2 (first pair seeds), rd_freq_valid=1; updated pulses with upd_chan=1, 3 cycles after its final Q.
- Channel 2 rotating CW with period=4 → rd_freq=-4, valid=1; channels 0 and 3, constant phase → rd_freq=0, valid=1.
- Channel 0 jumps from (+500,+500) to (-500,-500) → that window has rd_freq_valid=0; the next window is valid again.
- Channel 3 I = Q = -2^(DW-1) → rd_amp_max = 2^(AW-1); a mix of full-scale and 0 samples → rd_amp_min=0.
- Two consecutive I beats, then a Q beat for a mismatched channel → two protocol_err pulses, the affected windows invalid, the other channels unaffected.
- Assert rst_n low mid-window for 1 cycle, then continue → no updated pulse until a full new window completes; all rd_* read 0 until then.
